// File: rtl/piho_pkg.sv
// Shared constants for the path-integral result divider: default widths,
// settle delay and the FSM state encoding.
package piho_pkg;

    localparam int DEF_DW     = 64;
    localparam int DEF_SW     = 32;
    localparam int DEF_SETTLE = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DIV    = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/piho_seqdiv.sv
// Restoring unsigned divider: one quotient bit per cycle, MSB first, DW cycles.
// start loads the operands; done pulses for one cycle with the final result.
module piho_seqdiv #(
    parameter int DW = 64,
    parameter int SW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          done
);
    localparam int CW = $clog2(DW);

    logic [SW:0]   rem_q;
    logic [DW-1:0] quo_q;
    logic [SW-1:0] dvs_q;
    logic [CW-1:0] cnt_q;
    logic          running;
    logic [SW:0]   trial;
    logic          take;

    // The dividend shifts out of quo_q's top while quotient bits shift in below.
    always_comb begin
        trial = (rem_q << 1) | (SW+1)'(quo_q[DW-1]);
        take  = (trial >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q   <= '0;
                quo_q   <= dividend;
                dvs_q   <= divisor;
                cnt_q   <= CW'(DW - 1);
                running <= 1'b1;
            end else if (running) begin
                rem_q <= take ? (trial - {1'b0, dvs_q}) : trial;
                quo_q <= {quo_q[DW-2:0], take};
                if (cnt_q == '0) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q[SW-1:0];

endmodule

// File: rtl/piho_result_div.sv
// Waits for the path-integral run to finish, lets the adder tree settle,
// then divides x2sumall by nsamples and offers the result on a valid/ready port.
module piho_result_div
    import piho_pkg::*;
#(
    parameter int SETTLE = DEF_SETTLE,
    parameter int DW     = DEF_DW,
    parameter int SW     = DEF_SW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          finish,
    input  logic [DW-1:0] x2sumall,
    input  logic [SW-1:0] nsamples,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          div_zero,
    output logic          busy
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]    state;
    logic          finish_d;
    logic          armed;
    logic [3:0]    settle_cnt;
    logic          rise;
    logic          capture;
    logic          div_start;
    logic          div_done;
    logic [DW-1:0] div_quo;
    logic [SW-1:0] div_rem;

    // armed stays low until finish is seen low, so a level held across reset never starts a run.
    assign rise      = finish && !finish_d && armed;
    assign capture   = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
    assign div_start = capture && (nsamples != '0);
    assign busy      = (state != ST_IDLE);

    piho_seqdiv #(.DW(DW), .SW(SW)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (x2sumall),
        .divisor   (nsamples),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    // Handshake: once res_valid is high, it and the result hold until an edge with
    // res_ready=1 completes the transfer; res_ready means nothing while res_valid is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            finish_d   <= 1'b0;
            armed      <= 1'b0;
            settle_cnt <= '0;
            quotient   <= '0;
            remainder  <= '0;
            res_valid  <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            finish_d <= finish;
            armed    <= armed | ~finish;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (capture) begin
                        if (nsamples == '0) begin
                            state <= ST_HOLD;
                        end else begin
                            state    <= ST_DIV;
                            div_zero <= 1'b0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state     <= ST_HOLD;
                        quotient  <= div_quo;
                        remainder <= div_rem;
                        res_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Entering HOLD without a valid result means the captured divisor was zero.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        quotient  <= '1;
                        remainder <= '0;
                        div_zero  <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
